// File: rtl/fifo_drain_if.sv
// Handshake bundle between the FIFO read port, the drain and the downstream stream.
// Carries out_parity only when FIFO_DRAIN_PARITY_EN is defined.
interface fifo_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd_val;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
`ifdef FIFO_DRAIN_PARITY_EN
    logic                  out_parity;
`endif

`ifdef FIFO_DRAIN_PARITY_EN
    modport master (
        input  fifo_rd_val,
        output fifo_rd_en,
        input  fifo_rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last,
        output out_parity
    );

    modport slave (
        output fifo_rd_val,
        input  fifo_rd_en,
        output fifo_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last,
        input  out_parity
    );
`else
    modport master (
        input  fifo_rd_val,
        output fifo_rd_en,
        input  fifo_rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        output fifo_rd_val,
        input  fifo_rd_en,
        output fifo_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
`endif
endinterface

// File: rtl/fifo_drain.sv
// FIFO read-side drain: two-entry skid buffer absorbing the one-cycle read latency,
// packetised valid/ready output. Optional even-parity output under FIFO_DRAIN_PARITY_EN.
module fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_W      = $clog2(PKT_LEN) + 1
) (
    input  logic          clk,
    input  logic          reset,
    fifo_drain_if.master  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

    logic                  pend_reg;
    logic [1:0]            occ_reg;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [CNT_W-1:0]      word_cnt_reg;
    logic [DATA_WIDTH-1:0] skid_reg [2];

    logic                  pop;
    logic                  capture;
    logic                  credit_ok;
    logic [2:0]            committed;
    logic [1:0]            occ_next;
    logic [CNT_W-1:0]      word_cnt_next;

    assign bus.out_valid = (occ_reg != 2'd0);
    assign bus.out_data  = skid_reg[rd_ptr_reg];
    assign bus.out_last  = bus.out_valid & (word_cnt_reg == LAST_CNT);

    assign pop     = bus.out_valid & bus.out_ready;
    assign capture = pend_reg;

    // Words held plus the one in flight must stay below 2 after this cycle's pop,
    // so the buffer can never be overrun; out_ready feeds this path combinationally.
    assign committed  = {1'b0, occ_reg} + {2'b00, pend_reg};
    assign credit_ok  = committed < (3'd2 + {2'b00, pop});
    assign bus.fifo_rd_en = bus.fifo_rd_val & reset & credit_ok;

    assign occ_next      = occ_reg + {1'b0, capture} - {1'b0, pop};
    assign word_cnt_next = (word_cnt_reg == LAST_CNT) ? '0 : word_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg     <= 1'b0;
            occ_reg      <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            word_cnt_reg <= '0;
        end else begin
            pend_reg <= bus.fifo_rd_en;
            occ_reg  <= occ_next;
            if (capture) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg   <= ~rd_ptr_reg;
                word_cnt_reg <= word_cnt_next;
            end
        end
    end

    // Storage is cleared on reset so out_data reads 0 while idle after reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_skid
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                skid_reg[gi] <= '0;
            end else if (capture && (wr_ptr_reg == 1'(gi))) begin
                skid_reg[gi] <= bus.fifo_rd_data;
            end
        end
    end

`ifdef FIFO_DRAIN_PARITY_EN
    assign bus.out_parity = bus.out_valid & (^bus.out_data);
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: behavioural FIFO with registered read plus
// an expected-word scoreboard; parity scenario runs when FIFO_DRAIN_PARITY_EN is defined.
module tb_fifo_drain;

    localparam int DW      = 8;
    localparam int PKT_LEN = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fifo_drain_if #(.DATA_WIDTH(DW)) ifc ();

    fifo_drain #(
        .DATA_WIDTH(DW),
        .PKT_LEN   (PKT_LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.master)
    );

    // Behavioural source FIFO: data appears the cycle after an accepted pop.
    logic [DW-1:0] mem [256];
    logic [7:0]    wr_cnt = 8'd0;
    logic [7:0]    rd_cnt = 8'd0;

    assign ifc.fifo_rd_val = (wr_cnt != rd_cnt);

    always @(posedge clk) begin
        if (ifc.fifo_rd_en) begin
            ifc.fifo_rd_data <= mem[rd_cnt];
            rd_cnt           <= rd_cnt + 8'd1;
        end
    end

    exp_t exp_q[$];
    int   exp_pos = 0;
    int   total   = 0;
    int   bad     = 0;

    task automatic push_word(input logic [DW-1:0] d);
        exp_t e;
        mem[wr_cnt] = d;
        wr_cnt      = wr_cnt + 8'd1;
        e.last      = (exp_pos == PKT_LEN - 1);
        e.data      = d;
        exp_q.push_back(e);
        exp_pos = (exp_pos + 1) % PKT_LEN;
    endtask

    // Reset for two edges, empty the source FIFO and scoreboard, release after the edge.
    task automatic apply_reset();
        reset         = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_cnt  = rd_cnt;
        exp_q.delete();
        exp_pos = 0;
        reset   = 1'b1;
    endtask

    task automatic settle_cycle(input logic rdy);
        @(posedge clk);
        #1;
        ifc.out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset         = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_cnt  = rd_cnt;
        exp_q.delete();
        exp_pos = 0;
        push_word(8'hA5);
        @(posedge clk);
        #2;
        total++; if (ifc.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b, required 0", ifc.fifo_rd_en); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", ifc.out_valid); end
        total++; if (ifc.out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b, required 0", ifc.out_last); end
        total++; if (ifc.out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h, required 00", ifc.out_data); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++; if (ifc.fifo_rd_en !== 1'b1) begin bad++; $display("FAIL lat_c0_rd_en: got %b, required 1", ifc.fifo_rd_en); end
        settle_cycle(1'b0);
        total++; if (ifc.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL lat_c1_rd_en: got %b, required 0", ifc.fifo_rd_en); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL lat_c1_valid: got %b, required 0", ifc.out_valid); end
        settle_cycle(1'b1);
        e = exp_q.pop_front();
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL lat_c2_valid: got %b, required 1", ifc.out_valid); end
        total++; if (ifc.out_data !== e.data || ifc.out_last !== e.last) begin
            bad++; $display("FAIL lat_c2_word: got data=%h last=%b, required data=%h last=%b", ifc.out_data, ifc.out_last, e.data, e.last);
        end
        $display("test_reset: done");
    endtask

    task automatic test_streaming();
        exp_t e;
        int   vcount = 0;
        int   first  = -1;
        int   lastc  = -1;
        apply_reset();
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        for (int cyc = 0; cyc < 20; cyc++) begin
            settle_cycle(1'b1);
            if (ifc.out_valid) begin
                vcount++;
                if (first < 0) first = cyc;
                lastc = cyc;
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL stream_extra: got data=%h, required no word", ifc.out_data);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (ifc.out_data !== e.data || ifc.out_last !== e.last) begin
                        bad++; $display("FAIL stream_word: got data=%h last=%b, required data=%h last=%b", ifc.out_data, ifc.out_last, e.data, e.last);
                    end
                end
            end
        end
        total++; if (vcount != 8) begin bad++; $display("FAIL stream_count: got %0d valid cycles, required 8", vcount); end
        total++; if (lastc - first != 7) begin bad++; $display("FAIL stream_gap: got span %0d, required 7", lastc - first); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_left: got %0d undelivered, required 0", exp_q.size()); end
        $display("test_streaming: %0d words", vcount);
    endtask

    task automatic test_backpressure();
        exp_t       e;
        logic [7:0] rd_base;
        int         got = 0;
        apply_reset();
        rd_base = rd_cnt;
        for (int i = 0; i < 5; i++) push_word(8'h10 + DW'(i));
        for (int cyc = 0; cyc < 6; cyc++) begin
            settle_cycle(1'b0);
            if (ifc.out_valid) begin
                total++; if (ifc.out_data !== 8'h10) begin bad++; $display("FAIL bp_hold: got %h, required 10", ifc.out_data); end
            end
        end
        total++; if (ifc.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en: got %b, required 0", ifc.fifo_rd_en); end
        total++; if (rd_cnt - rd_base !== 8'd2) begin bad++; $display("FAIL bp_pops: got %0d, required 2", rd_cnt - rd_base); end
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b, required 1", ifc.out_valid); end
        for (int cyc = 0; cyc < 20; cyc++) begin
            settle_cycle(1'b1);
            if (ifc.out_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL bp_extra: got data=%h, required no word", ifc.out_data);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (ifc.out_data !== e.data || ifc.out_last !== e.last) begin
                        bad++; $display("FAIL bp_word: got data=%h last=%b, required data=%h last=%b", ifc.out_data, ifc.out_last, e.data, e.last);
                    end
                end
            end
        end
        total++; if (got != 5) begin bad++; $display("FAIL bp_count: got %0d words, required 5", got); end
        $display("test_backpressure: %0d words", got);
    endtask

    task automatic test_toggle();
        exp_t       e;
        logic [7:0] rd_base;
        int         acc = 0;
        int         held;
        apply_reset();
        rd_base = rd_cnt;
        for (int i = 0; i < 12; i++) push_word(8'h40 + DW'(i));
        for (int cyc = 0; cyc < 60; cyc++) begin
            settle_cycle(cyc % 2 == 0);
            held = int'(rd_cnt - rd_base) - acc;
            total++; if (held > 2) begin bad++; $display("FAIL toggle_held: got %0d, required <=2", held); end
            if (ifc.out_valid && ifc.out_ready) begin
                acc++;
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL toggle_extra: got data=%h, required no word", ifc.out_data);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (ifc.out_data !== e.data || ifc.out_last !== e.last) begin
                        bad++; $display("FAIL toggle_word: got data=%h last=%b, required data=%h last=%b", ifc.out_data, ifc.out_last, e.data, e.last);
                    end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL toggle_left: got %0d undelivered, required 0", exp_q.size()); end
        $display("test_toggle: %0d words", acc);
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   got = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) push_word(8'h20 + DW'(i));
        settle_cycle(1'b0);
        settle_cycle(1'b0);
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b, required 1", ifc.out_valid); end
        reset = 1'b0;
        #1;
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b, required 0", ifc.out_valid); end
        total++; if (ifc.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en: got %b, required 0", ifc.fifo_rd_en); end
        repeat (2) @(posedge clk);
        #1;
        wr_cnt  = rd_cnt;
        exp_q.delete();
        exp_pos = 0;
        for (int i = 1; i <= 4; i++) push_word(8'h30 + DW'(i));
        reset = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            settle_cycle(1'b1);
            if (ifc.out_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    total++; bad++; $display("FAIL mid_extra: got data=%h, required no word", ifc.out_data);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (ifc.out_data !== e.data || ifc.out_last !== e.last) begin
                        bad++; $display("FAIL mid_word: got data=%h last=%b, required data=%h last=%b", ifc.out_data, ifc.out_last, e.data, e.last);
                    end
                end
            end
        end
        total++; if (got != 4) begin bad++; $display("FAIL mid_count: got %0d words, required 4", got); end
        $display("test_mid_reset: %0d words", got);
    endtask

`ifdef FIFO_DRAIN_PARITY_EN
    task automatic test_parity();
        logic exp_par [2];
        int   idx = 0;
        exp_par[0] = 1'b0;
        exp_par[1] = 1'b1;
        apply_reset();
        push_word(8'h03);
        push_word(8'h07);
        for (int cyc = 0; cyc < 10; cyc++) begin
            settle_cycle(1'b1);
            if (!ifc.out_valid) begin
                total++; if (ifc.out_parity !== 1'b0) begin bad++; $display("FAIL parity_idle: got %b, required 0", ifc.out_parity); end
            end else if (idx < 2) begin
                total++;
                if (ifc.out_parity !== exp_par[idx]) begin
                    bad++; $display("FAIL parity_word%0d: got %b, required %b", idx, ifc.out_parity, exp_par[idx]);
                end
                idx++;
            end
        end
        total++; if (idx != 2) begin bad++; $display("FAIL parity_count: got %0d words, required 2", idx); end
        $display("test_parity: %0d words", idx);
    endtask
`endif

    initial begin
        ifc.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_toggle();
        test_mid_reset();
`ifdef FIFO_DRAIN_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
